ether_tx_sched: RTL and testbench
=================================

ETHER_TX_SCHED -- requirements
Module: ether_tx_sched

Interface
REQ-001 Parameter IFG_NIBBLES, default 24, SHALL set the inter-frame gap length in clk cycles (96 bit times at 4 bits/cycle).
REQ-002 Parameter MAX_NIBBLES, default 3036, SHALL set the maximum payload nibbles per frame (1518 bytes).
REQ-003 Parameter PRE_NIBBLES, default 15, SHALL set the number of 4'b0101 preamble nibbles before the SFD nibble.
REQ-004 Ports SHALL be:
- clk  in  1  sole clock
- rst  in  1  asynchronous, active-high reset
- s0_axis_tdata  in  4  requester 0 frame nibble, low nibble of each byte first
- s0_axis_tvalid  in  1  requester 0 nibble valid / transmit request
- s0_axis_tlast  in  1  requester 0 final nibble of frame
- s0_axis_tready  out  1  requester 0 nibble accepted
- s1_axis_tdata / s1_axis_tvalid / s1_axis_tlast / s1_axis_tready  same as s0, requester 1
- ether_txd  out  4  PHY transmit nibble
- ether_txen  out  1  PHY transmit enable
- grant  out  2  one-hot owner of current frame, 2'b00 when none
- busy  out  1  high in any state other than IDLE
- frame_done  out  1  one-cycle pulse, frame ended normally
- err_underrun  out  1  one-cycle pulse, granted tvalid low mid-payload
- err_oversize  out  1  one-cycle pulse, MAX_NIBBLES reached without tlast

Function
REQ-005 States SHALL be IDLE, PREAMBLE, SFD, PAYLOAD, DRAIN, IFG.
REQ-006 In IDLE with s0 or s1 tvalid high at edge k, the block SHALL set grant and enter PREAMBLE; ether_txen=1, ether_txd=4'b0101 from cycle k+1.
REQ-007 PREAMBLE SHALL last PRE_NIBBLES cycles, then SFD SHALL drive ether_txd=4'b1101 for exactly one cycle (ether_txen=1).
REQ-008 grant SHALL stay constant from PREAMBLE entry until IFG exit; the other requester's tready SHALL stay 0.
REQ-009 In PAYLOAD, granted tready SHALL be 1; each handshake SHALL register tdata to ether_txd with ether_txen=1 on the next cycle (1-cycle latency).
REQ-010 Handshake with tlast=1 SHALL pulse frame_done and enter IFG after that nibble is driven.
REQ-011 Granted tvalid=0 in any PAYLOAD cycle SHALL pulse err_underrun, drop ether_txen next cycle, and enter DRAIN.
REQ-012 Payload nibble counter (12 bits) reaching MAX_NIBBLES without tlast SHALL pulse err_oversize, drop ether_txen, and enter DRAIN; the MAX_NIBBLES-th nibble SHALL be transmitted.
REQ-013 DRAIN SHALL hold granted tready=1, ether_txen=0, discard nibbles, and enter IFG on a tlast handshake.
REQ-014 IFG SHALL hold ether_txen=0, all tready=0 for IFG_NIBBLES cycles, then clear grant and return to IDLE.
REQ-015 ether_txd SHALL be 4'b0000 whenever ether_txen=0.
REQ-016 busy, grant, tready SHALL be combinational from state; ether_txd, ether_txen, pulses SHALL be registered.

Reset
REQ-017 rst SHALL asynchronously force IDLE, grant=0, ether_txen=0, ether_txd=0, all tready=0, all pulses=0, counters=0, priority pointer to requester 0.
REQ-018 rst asserted mid-frame SHALL drop ether_txen immediately; no IFG SHALL be enforced after rst release.

Configuration
REQ-019 With ETHER_TX_RR_EN defined, simultaneous requests in IDLE SHALL be granted round-robin: requester not granted last wins; pointer updates on each grant.
REQ-020 Without ETHER_TX_RR_EN, simultaneous requests SHALL always grant requester 0 (fixed priority).

Verification
REQ-021 s0 sends 8-nibble frame from IDLE -> 15x 4'h5, 4'hD, then 8 payload nibbles on ether_txd with txen=1 for 24 cycles; frame_done pulses once; busy clears 24 cycles after last nibble.
REQ-022 s0 and s1 request together three times, RR_EN defined -> grants 01,10,01; without RR_EN -> 01,01,01.
REQ-023 s1 drops tvalid after 4 payload nibbles -> err_underrun pulse, txen low next cycle, s1_tready held until tlast, then 24-cycle IFG.
REQ-024 s0 streams 3100 nibbles, MAX_NIBBLES=3036 -> exactly 3036 payload nibbles transmitted, err_oversize pulse, remaining 64 drained.
REQ-025 rst asserted at payload nibble 10 -> txen=0 and grant=00 same cycle; pending s1 request after rst release starts preamble next cycle.
REQ-026 s1 tvalid high during s0's IFG -> s1 preamble begins only the cycle after IFG ends, s1_tready=0 throughout IFG.

Source files
------------

// File: rtl/ether_tx_sched.sv
// ether_tx_sched: two-requester MII nibble transmitter with preamble/SFD, IFG spacing and error drain.
// Define ETHER_TX_RR_EN for round-robin arbitration; otherwise requester 0 has fixed priority.
module ether_tx_sched #(
  parameter int IFG_NIBBLES = 24,
  parameter int MAX_NIBBLES = 3036,
  parameter int PRE_NIBBLES = 15
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] s0_axis_tdata,
  input  logic       s0_axis_tvalid,
  input  logic       s0_axis_tlast,
  output logic       s0_axis_tready,
  input  logic [3:0] s1_axis_tdata,
  input  logic       s1_axis_tvalid,
  input  logic       s1_axis_tlast,
  output logic       s1_axis_tready,
  output logic [3:0] ether_txd,
  output logic       ether_txen,
  output logic [1:0] grant,
  output logic       busy,
  output logic       frame_done,
  output logic       err_underrun,
  output logic       err_oversize
);
  typedef enum logic [2:0] {IDLE, PREAMBLE, SFD, PAYLOAD, DRAIN, IFG} state_t;
  state_t state;
  logic owner, win, req_valid, req_last, accept, pre_end;
  logic [3:0] req_data;
  logic [11:0] cnt;
  assign req_valid = owner ? s1_axis_tvalid : s0_axis_tvalid;
  assign req_last = owner ? s1_axis_tlast : s0_axis_tlast;
  assign req_data = owner ? s1_axis_tdata : s0_axis_tdata;
  // the SFD cycle already accepts the first nibble so payload follows the SFD without a gap
  assign accept = state == SFD || state == PAYLOAD || state == DRAIN;
  assign s0_axis_tready = accept && !owner;
  assign s1_axis_tready = accept && owner;
  assign busy = state != IDLE;
  assign grant = busy ? (owner ? 2'b10 : 2'b01) : 2'b00;
  assign pre_end = cnt == 12'(PRE_NIBBLES - 1);
`ifdef ETHER_TX_RR_EN
  logic prio;
  assign win = s0_axis_tvalid && s1_axis_tvalid ? prio : s1_axis_tvalid;
  always_ff @(posedge clk or posedge rst)
    if (rst) prio <= 1'b0;
    else if (state == IDLE && (s0_axis_tvalid || s1_axis_tvalid)) prio <= !win;
`else
  assign win = !s0_axis_tvalid;
`endif
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      owner <= 1'b0;
      cnt <= '0;
      ether_txd <= 4'h0;
      ether_txen <= 1'b0;
      frame_done <= 1'b0;
      err_underrun <= 1'b0;
      err_oversize <= 1'b0;
    end else begin
      ether_txd <= 4'h0;
      ether_txen <= 1'b0;
      frame_done <= 1'b0;
      err_underrun <= 1'b0;
      err_oversize <= 1'b0;
      case (state)
        IDLE: if (s0_axis_tvalid || s1_axis_tvalid) begin
          state <= PREAMBLE;
          owner <= win;
          cnt <= '0;
          ether_txen <= 1'b1;
          ether_txd <= 4'h5;
        end
        PREAMBLE: begin
          ether_txen <= 1'b1;
          ether_txd <= pre_end ? 4'hd : 4'h5;
          cnt <= pre_end ? '0 : cnt + 12'd1;
          if (pre_end) state <= SFD;
        end
        SFD, PAYLOAD: if (!req_valid) begin
          err_underrun <= 1'b1;
          state <= DRAIN;
        end else begin
          ether_txen <= 1'b1;
          ether_txd <= req_data;
          cnt <= cnt + 12'd1;
          if (req_last) begin
            frame_done <= 1'b1;
            cnt <= '0;
            state <= IFG;
          end else if (cnt == 12'(MAX_NIBBLES - 1)) begin
            err_oversize <= 1'b1;
            state <= DRAIN;
          end else state <= PAYLOAD;
        end
        DRAIN: if (req_valid && req_last) begin
          cnt <= '0;
          state <= IFG;
        end
        IFG: begin
          cnt <= cnt + 12'd1;
          if (cnt == 12'(IFG_NIBBLES - 1)) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_ether_tx_sched.sv
// tb_ether_tx_sched: scoreboard of expected PHY nibbles plus table-driven frame rows and
// hand-written underrun, oversize, reset and arbitration sequences.
module tb_ether_tx_sched;
  localparam int IFG = 24;
  localparam int MAXN = 3036;
  localparam int PRE = 15;
`ifdef ETHER_TX_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif
  logic clk = 1'b0, rst = 1'b1;
  logic [3:0] s0_d = 4'h0, s1_d = 4'h0;
  logic s0_v = 1'b0, s0_l = 1'b0, s1_v = 1'b0, s1_l = 1'b0;
  logic s0_axis_tready, s1_axis_tready, ether_txen, busy, frame_done, err_underrun, err_oversize;
  logic [3:0] ether_txd;
  logic [1:0] grant;
  always #5 clk = ~clk;
  ether_tx_sched #(.IFG_NIBBLES(IFG), .MAX_NIBBLES(MAXN), .PRE_NIBBLES(PRE)) dut (
    .clk(clk), .rst(rst),
    .s0_axis_tdata(s0_d), .s0_axis_tvalid(s0_v), .s0_axis_tlast(s0_l), .s0_axis_tready(s0_axis_tready),
    .s1_axis_tdata(s1_d), .s1_axis_tvalid(s1_v), .s1_axis_tlast(s1_l), .s1_axis_tready(s1_axis_tready),
    .ether_txd(ether_txd), .ether_txen(ether_txen), .grant(grant), .busy(busy),
    .frame_done(frame_done), .err_underrun(err_underrun), .err_oversize(err_oversize)
  );
  typedef struct {
    logic [1:0] req;
    int len0, len1, base0, base1;
  } vec_t;
  int n_checks = 0, n_fail = 0;
  logic [3:0] sb[$];
  logic [1:0] gq[$];
  int cyc = 0, last_hi = 0, last_gap = 0, n_txen = 0, n_done = 0, n_under = 0, n_over = 0;
  bit busy_q = 1'b0, txen_q = 1'b0, mprio = 1'b0;

  task automatic check(string name, int act, int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic logic [3:0] nib(int base, int i);
    return 4'(base + 3 * i + (i >> 4));
  endfunction

  // arbitration model: returns the requester expected to win
  function automatic int pick(logic [1:0] req);
    int w = req == 2'b11 ? (RR ? int'(mprio) : 0) : (req == 2'b10 ? 1 : 0);
    if (RR) mprio = (w == 0);
    return w;
  endfunction

  task automatic push_frame(int base, int m);
    repeat (PRE) sb.push_back(4'h5);
    sb.push_back(4'hd);
    for (int i = 0; i < m; i++) sb.push_back(nib(base, i));
  endtask

  task automatic set(int r, bit v, logic [3:0] d, bit l);
    if (r == 0) begin s0_v = v; s0_d = d; s0_l = l; end
    else begin s1_v = v; s1_d = d; s1_l = l; end
  endtask

  task automatic drive(int r, int n, int base, int gap_at, output bit ok);
    ok = 1'b1;
    for (int i = 0; i < n; i++) begin
      bit hs = 1'b0;
      int t = 0;
      if (i == gap_at) begin
        set(r, 1'b0, 4'h0, 1'b0);
        @(posedge clk); #1;
      end
      set(r, 1'b1, nib(base, i), i == n - 1);
      while (!hs && t < 300) begin
        @(negedge clk);
        hs = r ? s1_axis_tready : s0_axis_tready;
        @(posedge clk); #1;
        t++;
      end
      if (!hs) begin
        ok = 1'b0;
        set(r, 1'b0, 4'h0, 1'b0);
        return;
      end
    end
    set(r, 1'b0, 4'h0, 1'b0);
  endtask

  task automatic wait_idle(output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (busy && n < 5000);
  endtask

  task automatic check_grant(logic [1:0] exp);
    check("grant_seq", gq.size() > 0 ? int'(gq.pop_front()) : -1, int'(exp));
  endtask

  always @(negedge clk) begin
    cyc++;
    if (ether_txen) begin
      if (sb.size() == 0) check("sb_has_nibble", sb.size(), 1);
      else check("txd", ether_txd, sb.pop_front());
      n_txen++;
      if (!txen_q) last_gap = cyc - last_hi;
      last_hi = cyc;
    end else check("txd_idle_zero", ether_txd, 0);
    check("s0_tready_owner", s0_axis_tready && grant != 2'b01, 0);
    check("s1_tready_owner", s1_axis_tready && grant != 2'b10, 0);
    if (busy && !busy_q) gq.push_back(grant);
    n_done += int'(frame_done);
    n_under += int'(err_underrun);
    n_over += int'(err_oversize);
    busy_q = busy;
    txen_q = ether_txen;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vec_t vt[7];
    int n, w, w2, d0, t0, u0, o0, cnt;
    bit ok, ok0, ok1;
    vt[0] = '{2'b01, 5, 0, 7, 0};
    vt[1] = '{2'b10, 0, 7, 0, 9};
    vt[2] = '{2'b11, 6, 4, 1, 11};
    vt[3] = '{2'b11, 3, 9, 4, 13};
    vt[4] = '{2'b10, 0, 1, 0, 6};
    vt[5] = '{2'b11, 1, 2, 8, 3};
    vt[6] = '{2'b01, 16, 0, 5, 0};
    repeat (3) @(negedge clk);
    check("rst_txen", ether_txen, 0);
    check("rst_txd", ether_txd, 0);
    check("rst_grant", grant, 0);
    check("rst_busy", busy, 0);
    check("rst_s0_tready", s0_axis_tready, 0);
    check("rst_s1_tready", s1_axis_tready, 0);
    check("rst_frame_done", frame_done, 0);
    check("rst_err_underrun", err_underrun, 0);
    check("rst_err_oversize", err_oversize, 0);
    #1 rst = 1'b0;
    for (int t = 0; t < 3; t++) begin
      @(posedge clk); #1;
      set(0, 1'b1, nib(4, 0), 1'b0);
      set(1, 1'b1, nib(9, 0), 1'b0);
      w = pick(2'b11);
      push_frame(w ? 9 : 4, 6);
      @(posedge clk); #1;
      check("arb_grant", grant, w ? 2 : 1);
      set(1 - w, 1'b0, 4'h0, 1'b0);
      drive(w, 6, w ? 9 : 4, -1, ok);
      check("arb_drive_ok", ok, 1);
      wait_idle(n);
      check("arb_ifg", n, IFG + 1);
      check_grant(w ? 2'b10 : 2'b01);
    end
    d0 = n_done; t0 = n_txen;
    void'(pick(2'b01));
    push_frame(2, 8);
    drive(0, 8, 2, -1, ok);
    check("basic_drive_ok", ok, 1);
    wait_idle(n);
    check("basic_busy_clear", n, IFG + 1);
    check("basic_frame_done", n_done - d0, 1);
    check("basic_txen_cycles", n_txen - t0, PRE + 1 + 8);
    check("basic_sb_empty", sb.size(), 0);
    check_grant(2'b01);
    foreach (vt[k]) begin
      d0 = n_done;
      ok0 = 1'b1; ok1 = 1'b1;
      w = pick(vt[k].req);
      push_frame(w ? vt[k].base1 : vt[k].base0, w ? vt[k].len1 : vt[k].len0);
      w2 = -1;
      if (vt[k].req == 2'b11) begin
        w2 = pick(w ? 2'b01 : 2'b10);
        push_frame(w2 ? vt[k].base1 : vt[k].base0, w2 ? vt[k].len1 : vt[k].len0);
      end
      fork
        begin if (vt[k].req[0]) drive(0, vt[k].len0, vt[k].base0, -1, ok0); end
        begin if (vt[k].req[1]) drive(1, vt[k].len1, vt[k].base1, -1, ok1); end
      join
      check("row_drive_ok", ok0 && ok1, 1);
      wait_idle(n);
      check("row_ifg", n, IFG + 1);
      check("row_frame_done", n_done - d0, w2 < 0 ? 1 : 2);
      check("row_sb_empty", sb.size(), 0);
      check_grant(w ? 2'b10 : 2'b01);
      if (w2 >= 0) begin
        check_grant(w2 ? 2'b10 : 2'b01);
        check("row_ifg_gap", last_gap, IFG + 1);
      end
    end
    d0 = n_done; t0 = n_txen; u0 = n_under;
    void'(pick(2'b10));
    push_frame(12, 4);
    drive(1, 10, 12, 4, ok);
    check("under_drain_ok", ok, 1);
    wait_idle(n);
    check("under_ifg", n, IFG + 1);
    check("under_pulse", n_under - u0, 1);
    check("under_no_done", n_done - d0, 0);
    check("under_txen_cycles", n_txen - t0, PRE + 1 + 4);
    check("under_sb_empty", sb.size(), 0);
    check_grant(2'b10);
    d0 = n_done; t0 = n_txen; o0 = n_over;
    void'(pick(2'b01));
    push_frame(14, MAXN);
    drive(0, 3100, 14, -1, ok);
    check("over_drain_ok", ok, 1);
    wait_idle(n);
    check("over_ifg", n, IFG + 1);
    check("over_pulse", n_over - o0, 1);
    check("over_no_done", n_done - d0, 0);
    check("over_txen_cycles", n_txen - t0, PRE + 1 + MAXN);
    check("over_sb_empty", sb.size(), 0);
    check_grant(2'b01);
    void'(pick(2'b01));
    push_frame(10, 9);
    set(0, 1'b1, nib(10, 0), 1'b0);
    @(posedge clk); #1;
    set(1, 1'b1, nib(5, 0), 1'b0);
    cnt = 0; n = 0;
    while (cnt < 10 && n < 300) begin
      @(negedge clk);
      ok = s0_axis_tready;
      @(posedge clk); #1;
      n++;
      if (ok) begin
        cnt++;
        set(0, 1'b1, nib(10, cnt), 1'b0);
      end
    end
    check("rst_mid_handshakes", cnt, 10);
    rst = 1'b1;
    #1;
    check("rst_mid_txen", ether_txen, 0);
    check("rst_mid_grant", grant, 0);
    check("rst_mid_busy", busy, 0);
    check("rst_mid_sb_empty", sb.size(), 0);
    set(0, 1'b0, 4'h0, 1'b0);
    mprio = 1'b0;
    w = pick(2'b10);
    push_frame(5, 6);
    @(negedge clk); #1;
    check("rst_hold_s1_tready", s1_axis_tready, 0);
    rst = 1'b0;
    @(negedge clk);
    check("rst_release_grant", grant, 2);
    check("rst_release_txen", ether_txen, 1);
    drive(1, 6, 5, -1, ok);
    check("rst_release_drive_ok", ok, 1);
    wait_idle(n);
    check("rst_release_ifg", n, IFG + 1);
    check_grant(2'b01);
    check_grant(2'b10);
    check("final_sb_empty", sb.size(), 0);
    check("final_gq_empty", gq.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
